led_fader: RTL and testbench

- Downstream of the LED animation stage; consumes its 8-bit on/off LED pattern and drives the physical LED pins.
- Each LED has a brightness level that ramps one step per fade tick toward full-on or full-off, following its target bit.
- Each level is rendered as PWM, so hard on/off pattern edges become smooth fades.
- Runs on the board's 10 MHz system clock.

---
 rtl/led_fader_if.sv | 23 ++
 rtl/led_fader.sv | 82 ++++++++
 tb/tb_led_fader.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_fader_if.sv
// led_fader_if: animation-stage pattern in, LED pin drive and settled flag out.
interface led_fader_if #(
    parameter int NUM_LEDS = 8
);
    logic                enable;
    logic [NUM_LEDS-1:0] targets;
    logic [NUM_LEDS-1:0] pwm_out;
    logic                settled;

    modport master (
        output enable,
        output targets,
        input  pwm_out,
        input  settled
    );

    modport slave (
        input  enable,
        input  targets,
        output pwm_out,
        output settled
    );
endinterface

// File: rtl/led_fader.sv
// led_fader: per-LED brightness ramps one step per fade tick toward the
// registered on/off target and is rendered as registered PWM.
module led_fader #(
    parameter int NUM_LEDS   = 8,
    parameter int LEVEL_BITS = 8,
    parameter int PRESCALE   = 390
) (
    input  logic       clock,
    input  logic       reset,
    led_fader_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [LEVEL_BITS-1:0] MAX = '1;
    localparam logic [LEVEL_BITS-1:0] ONE = LEVEL_BITS'(1);

    logic [NUM_LEDS-1:0]   target_q;
    logic [PW-1:0]         prescaler;
    logic [LEVEL_BITS-1:0] pwm_cnt;
    logic [LEVEL_BITS-1:0] level [NUM_LEDS];
    logic                  tick;
    logic                  at_end;
    logic [NUM_LEDS-1:0]   pwm_d;

    assign tick = bus.enable && (prescaler == PS_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            target_q  <= '0;
            prescaler <= '0;
            pwm_cnt   <= '0;
        end else begin
            target_q <= bus.targets;
            pwm_cnt  <= pwm_cnt + ONE;
            if (bus.enable) begin
                if (prescaler == PS_LAST) begin
                    prescaler <= '0;
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

    // tick sees the previous target_q, so a new pattern acts from the next tick
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (target_q[i] && level[i] != MAX) begin
                    level[i] <= level[i] + ONE;
                end else if (!target_q[i] && level[i] != '0) begin
                    level[i] <= level[i] - ONE;
                end
            end
        end
    end

    always_comb begin
        pwm_d  = '0;
        at_end = 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pwm_d[i] = (level[i] == MAX) || (pwm_cnt < level[i]);
            if (target_q[i] ? (level[i] != MAX) : (level[i] != '0)) begin
                at_end = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.pwm_out <= '0;
            bus.settled <= 1'b1;
        end else begin
            bus.pwm_out <= pwm_d;
            bus.settled <= at_end;
        end
    end
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: randomized and directed scenarios checked against an
// integer-arithmetic model of the fade/PWM rules (MAX=7, PRESCALE=4).
module tb_led_fader;
    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] targets;

    int checks;
    int failures;

    // reference model state
    logic [7:0] m_tq;
    logic [7:0] m_pwm;
    logic       m_settled;
    int         m_lvl [8];
    int         m_en;
    int         m_cyc;
    logic       m_tick;

    led_fader_if #(.NUM_LEDS(8)) bus ();

    assign bus.enable  = enable;
    assign bus.targets = targets;

    led_fader #(
        .NUM_LEDS(8),
        .LEVEL_BITS(3),
        .PRESCALE(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) begin
            m_tq      = '0;
            m_pwm     = '0;
            m_settled = 1'b1;
            m_en      = 0;
            m_cyc     = 0;
            for (int i = 0; i < 8; i++) m_lvl[i] = 0;
        end else begin
            m_tick    = enable && (m_en % 4 == 3);
            if (enable) m_en++;
            m_settled = 1'b1;
            for (int i = 0; i < 8; i++) begin
                m_pwm[i] = (m_lvl[i] == 7) || ((m_cyc % 8) < m_lvl[i]);
                if (m_tq[i] ? (m_lvl[i] != 7) : (m_lvl[i] != 0))
                    m_settled = 1'b0;
                if (m_tick) begin
                    if (m_tq[i]) m_lvl[i] = (m_lvl[i] < 7) ? m_lvl[i] + 1 : 7;
                    else         m_lvl[i] = (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
                end
            end
            m_tq  = targets;
            m_cyc = m_cyc + 1;
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        targets = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== 8'h00 || bus.settled !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold: pwm_out=%h settled=%b want 00/1",
                         bus.pwm_out, bus.settled);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL reset_release c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
        end
    endtask

    task automatic test_fade_in();
        bit fell;
        enable  = 1'b1;
        targets = 8'h00;
        do_reset();
        targets = 8'h01;
        fell = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (bus.settled === 1'b0) fell = 1;
        end
        checks++;
        if (!fell) begin
            failures++;
            $display("FAIL fade_in_settled_drop: settled=%b want 0 within 2",
                     bus.settled);
        end
        for (int c = 0; c < 34; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL fade_in c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
            if (c == 20) begin
                checks++;
                if (bus.settled !== 1'b0) begin
                    failures++;
                    $display("FAIL fade_in_early: settled=%b want 0",
                             bus.settled);
                end
            end
        end
        checks++;
        if (bus.pwm_out !== 8'h01 || bus.settled !== 1'b1) begin
            failures++;
            $display("FAIL fade_in_done: pwm_out=%h settled=%b want 01/1",
                     bus.pwm_out, bus.settled);
        end
    endtask

    task automatic test_pwm_duty();
        int highs;
        int n;
        bit want;
        enable  = 1'b1;
        targets = 8'h00;
        do_reset();
        targets = 8'h01;
        n = 0;
        while (m_lvl[0] != 3 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (m_lvl[0] != 3) begin
            failures++;
            $display("FAIL pwm_duty_timeout: level model=%0d want 3", m_lvl[0]);
        end
        enable = 1'b0;
        step();
        step();
        highs = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            want = ((m_cyc - 1) % 8) < 3;
            if (bus.pwm_out[0] === 1'b1) highs++;
            checks++;
            if (bus.pwm_out !== {7'b0, want}) begin
                failures++;
                $display("FAIL pwm_duty_phase c=%0d: pwm_out=%h want %h",
                         c, bus.pwm_out, {7'b0, want});
            end
        end
        checks++;
        if (highs != 15) begin
            failures++;
            $display("FAIL pwm_duty_count: highs=%0d want 15", highs);
        end
        enable = 1'b1;
    endtask

    task automatic test_reversal();
        int n;
        enable  = 1'b1;
        targets = 8'h00;
        do_reset();
        targets = 8'h04;
        n = 0;
        while (m_lvl[2] != 4 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (m_lvl[2] != 4) begin
            failures++;
            $display("FAIL reversal_timeout: level model=%0d want 4", m_lvl[2]);
        end
        targets = 8'h00;
        for (int c = 0; c < 40; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL reversal c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
            if (c >= 24) begin
                checks++;
                if (bus.pwm_out[2] !== 1'b0 || bus.settled !== 1'b1) begin
                    failures++;
                    $display("FAIL reversal_floor c=%0d: pwm2=%b settled=%b want 0/1",
                             c, bus.pwm_out[2], bus.settled);
                end
            end
        end
    endtask

    task automatic test_saturation_enable();
        int highs;
        enable  = 1'b1;
        targets = 8'h00;
        do_reset();
        targets = 8'hFF;
        for (int c = 0; c < 100; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL saturate c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
        end
        checks++;
        if (bus.pwm_out !== 8'hFF || bus.settled !== 1'b1) begin
            failures++;
            $display("FAIL saturate_hold: pwm_out=%h settled=%b want FF/1",
                     bus.pwm_out, bus.settled);
        end
        targets = 8'h00;
        repeat (10) step();
        enable = 1'b0;
        highs  = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.pwm_out[0] === 1'b1) highs++;
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL freeze c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
        end
        checks++;
        if (highs == 0 || highs == 20) begin
            failures++;
            $display("FAIL freeze_pwm_runs: highs=%0d want between 1 and 19",
                     highs);
        end
        enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL resume c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        int n;
        enable  = 1'b1;
        targets = 8'h00;
        do_reset();
        targets = 8'hFF;
        n = 0;
        while (m_lvl[0] != 5 && n < 60) begin
            step();
            n++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.pwm_out !== 8'h00 || bus.settled !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_fade: pwm_out=%h settled=%b want 00/1",
                     bus.pwm_out, bus.settled);
        end
        for (int c = 0; c < 30; c++) begin
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL restart c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
        end
    endtask

    task automatic test_random();
        enable  = 1'b1;
        targets = 8'h00;
        do_reset();
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 15) == 0) targets = 8'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            step();
            checks++;
            if (bus.pwm_out !== m_pwm || bus.settled !== m_settled) begin
                failures++;
                $display("FAIL random c=%0d: pwm_out=%h settled=%b want %h/%b",
                         c, bus.pwm_out, bus.settled, m_pwm, m_settled);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        targets  = 8'h00;
        test_reset();
        test_fade_in();
        test_pwm_duty();
        test_reversal();
        test_saturation_enable();
        test_reset_mid_fade();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
